// File: rtl/ifid_stage.sv
// ifid_stage: fetch PC register plus IF/ID pipeline register.
// Holds on hazard stall, flushes on redirect from ID, and reports
// ID/EX bubbles, stall statistics and a stall-run watchdog.
//
// Control semantics: nopIFID is a level-sensitive hold request that
// applies at every rising edge where it is high. redirect is a
// single-cycle request that takes effect only when nopIFID is low at
// that edge. There is no ready/back-pressure path out of this block.
module ifid_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          STALL_MAX = 3,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nopIFID,
  input  logic             redirect,
  input  logic [31:0]      target,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      pc,
  output logic [31:0]      instr_id,
  output logic [31:0]      pc4_id,
  output logic             valid_id,
  output logic             bubble_idex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [2:0]       stall_run,
  output logic             stall_timeout,
  output logic             state_dbg
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         run_q, run_d;
  logic               tmo_q, tmo_d;
  logic [31:0]        pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state logic for the FSM, PC and IF/ID (stall > redirect > normal).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      RUN:     if (nopIFID)  state_d = STALL;
      STALL:   if (!nopIFID) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (nopIFID) begin
      // Hold everything; a same-cycle redirect is dropped and re-asserted later.
    end else if (redirect) begin
      pc_d    = {target[31:2], 2'b00};
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_instr;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // Next-state logic for stall statistics and the sticky watchdog.
  always_comb begin
    cnt_d = cnt_q;
    run_d = 3'd0;
    tmo_d = tmo_q;
    if (nopIFID) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      run_d = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;
      // This edge makes the run exceed STALL_MAX.
      if (int'(run_q) >= STALL_MAX) tmo_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      run_q   <= 3'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
    end
  end

  assign pc            = pc_q;
  assign instr_id      = instr_q;
  assign pc4_id        = pc4_q;
  assign valid_id      = valid_q;
  // Bubble only when a real instruction is frozen in ID, never under reset.
  assign bubble_idex   = nopIFID & valid_q & rst;
  assign stall_cnt     = cnt_q;
  assign stall_run     = run_q;
  assign stall_timeout = tmo_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ifid_stage.sv
// Directed bench for ifid_stage: reset, free-run, stall, redirect,
// stall+redirect collision, watchdog, reset mid-stall, target alignment.
module tb_ifid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        nopIFID;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] instr_id;
  logic [31:0] pc4_id;
  logic        valid_id;
  logic        bubble_idex;
  logic [15:0] stall_cnt;
  logic [2:0]  stall_run;
  logic        stall_timeout;
  logic        state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock
  always #5 clk = ~clk;

  ifid_stage #(
    .RESET_PC (32'h0000_3000),
    .STALL_MAX(3),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .nopIFID      (nopIFID),
    .redirect     (redirect),
    .target       (target),
    .imem_instr   (imem_instr),
    .pc           (pc),
    .instr_id     (instr_id),
    .pc4_id       (pc4_id),
    .valid_id     (valid_id),
    .bubble_idex  (bubble_idex),
    .stall_cnt    (stall_cnt),
    .stall_run    (stall_run),
    .stall_timeout(stall_timeout),
    .state_dbg    (state_dbg)
  );

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_pc,
                            input logic [31:0] e_instr, input logic [31:0] e_pc4,
                            input logic e_valid);
    check({tag, ".pc"},    pc,       e_pc);
    check({tag, ".instr"}, instr_id, e_instr);
    check({tag, ".pc4"},   pc4_id,   e_pc4);
    check({tag, ".valid"}, {31'd0, valid_id}, {31'd0, e_valid});
  endtask

  task automatic check_stats(input string tag, input logic [15:0] e_cnt,
                             input logic [2:0] e_run, input logic e_tmo);
    check({tag, ".cnt"}, {16'd0, stall_cnt}, {16'd0, e_cnt});
    check({tag, ".run"}, {29'd0, stall_run}, {29'd0, e_run});
    check({tag, ".tmo"}, {31'd0, stall_timeout}, {31'd0, e_tmo});
  endtask

  initial begin
    rst = 1'b0; nopIFID = 1'b0; redirect = 1'b0;
    target = 32'd0; imem_instr = 32'h2401_0001;

    // Reset state
    step(); step();
    check_ifid("reset", 32'h3000, 32'd0, 32'd0, 1'b0);
    check_stats("reset", 16'd0, 3'd0, 1'b0);
    check("reset.state", {31'd0, state_dbg}, 32'd0);
    nopIFID = 1'b1; #1;
    check("reset.bubble", {31'd0, bubble_idex}, 32'd0);
    nopIFID = 1'b0;

    // Free-run
    rst = 1'b1;
    step();
    check_ifid("run1", 32'h3004, 32'h2401_0001, 32'h3004, 1'b1);
    imem_instr = 32'h2402_0002;
    step();
    check_ifid("run2", 32'h3008, 32'h2402_0002, 32'h3008, 1'b1);

    // Two-cycle stall at pc=0x3008
    nopIFID = 1'b1; imem_instr = 32'h1111_1111; #1;
    check("stall0.bubble", {31'd0, bubble_idex}, 32'd1);
    step();
    check_ifid("stall1", 32'h3008, 32'h2402_0002, 32'h3008, 1'b1);
    check_stats("stall1", 16'd1, 3'd1, 1'b0);
    check("stall1.bubble", {31'd0, bubble_idex}, 32'd1);
    check("stall1.state", {31'd0, state_dbg}, 32'd1);
    step();
    check_ifid("stall2", 32'h3008, 32'h2402_0002, 32'h3008, 1'b1);
    check_stats("stall2", 16'd2, 3'd2, 1'b0);
    nopIFID = 1'b0; #1;
    check("stall_rel.bubble", {31'd0, bubble_idex}, 32'd0);
    step();
    check_ifid("after_stall", 32'h300c, 32'h1111_1111, 32'h300c, 1'b1);
    check_stats("after_stall", 16'd2, 3'd0, 1'b0);
    check("after_stall.state", {31'd0, state_dbg}, 32'd0);

    // Redirect to 0x3040
    redirect = 1'b1; target = 32'h3040; imem_instr = 32'h2222_2222;
    step();
    check_ifid("redir1", 32'h3040, 32'd0, 32'd0, 1'b0);
    redirect = 1'b0; imem_instr = 32'h3333_3333; #1;
    nopIFID = 1'b1; #1;
    check("redir1.bubble_novalid", {31'd0, bubble_idex}, 32'd0);
    nopIFID = 1'b0;
    step();
    check_ifid("redir2", 32'h3044, 32'h3333_3333, 32'h3044, 1'b1);

    // Stall and redirect together: stall wins
    nopIFID = 1'b1; redirect = 1'b1; target = 32'h3100; imem_instr = 32'h5555_5555;
    step();
    check_ifid("collide", 32'h3044, 32'h3333_3333, 32'h3044, 1'b1);
    check_stats("collide", 16'd3, 3'd1, 1'b0);
    nopIFID = 1'b0; redirect = 1'b0; imem_instr = 32'h4444_4444;
    step();
    check_ifid("collide_rel", 32'h3048, 32'h4444_4444, 32'h3048, 1'b1);
    check_stats("collide_rel", 16'd3, 3'd0, 1'b0);

    // Watchdog: 4-cycle stall run with STALL_MAX=3
    nopIFID = 1'b1;
    step(); step(); step();
    check_stats("tmo3", 16'd6, 3'd3, 1'b0);
    step();
    check_stats("tmo4", 16'd7, 3'd4, 1'b1);
    step(); step(); step(); step();
    check_stats("run_sat", 16'd11, 3'd7, 1'b1);
    check("run_sat.pc", pc, 32'h3048);
    nopIFID = 1'b0;
    step();
    check_ifid("tmo_rel", 32'h304c, 32'h4444_4444, 32'h304c, 1'b1);
    check_stats("tmo_rel", 16'd11, 3'd0, 1'b1);

    // Reset mid-stall with a pending redirect
    nopIFID = 1'b1;
    step();
    check_stats("pre_rst", 16'd12, 3'd1, 1'b1);
    rst = 1'b0; redirect = 1'b1; target = 32'h3200;
    step();
    check_ifid("mid_rst", 32'h3000, 32'd0, 32'd0, 1'b0);
    check_stats("mid_rst", 16'd0, 3'd0, 1'b0);
    check("mid_rst.state", {31'd0, state_dbg}, 32'd0);

    // Misaligned redirect target
    rst = 1'b1; nopIFID = 1'b0; redirect = 1'b1; target = 32'h3043;
    step();
    check_ifid("align", 32'h3040, 32'd0, 32'd0, 1'b0);
    redirect = 1'b0; imem_instr = 32'h6666_6666;
    step();
    check_ifid("align2", 32'h3044, 32'h6666_6666, 32'h3044, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
